// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by an internal FIFO; data bits, parity and stop bits fixed at elaboration.
// Latency: a word written at edge E0 into an idle, empty block is popped at E1; its start bit is on tx from E2.
// Backpressure: none beyond full; a write while full is dropped and flagged by a one-cycle overflow pulse.
// Optional: define UART_TX_BREAK_EN to add the brk input (hold the line low while idle, then one bit of mark).
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [DATA_BITS-1:0]        wr_data,
`ifdef UART_TX_BREAK_EN
   input  logic                        brk,
`endif
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        overflow,
   output logic                        tx_busy,
   output logic                        tx
);
   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(CPB);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int IW  = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
   localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);
   localparam logic          ODD       = (PARITY == 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK, MARK} state_t;

   state_t               state, state_n;
   logic [CW-1:0]        clk_cnt, cnt_n;
   logic [IW-1:0]        bit_idx, idx_n;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 push, pop, bit_done, tx_n, hold_brk;

`ifdef UART_TX_BREAK_EN
   assign hold_brk = brk;
`else
   assign hold_brk = 1'b0;
`endif

   assign full     = (count == DEPTH);
   assign empty    = (count == '0);
   assign level    = count;
   assign push     = wr_en && !full;
   assign bit_done = (clk_cnt == CNT_LAST);
   assign tx_busy  = (state != IDLE) || !empty;

   // FIFO storage; stale entries are unreachable through the occupancy count, so no reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // FIFO pointers, occupancy and the registered overflow pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en && full;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Transmit state, counters, latched frame word and the registered line output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_n;
         clk_cnt <= cnt_n;
         bit_idx <= idx_n;
         tx      <= tx_n;
         if (pop) shift <= mem[rd_ptr];
      end
   end

   // Next state and line level; tx is registered from the current state, so it lags state by one clk
   always_comb begin
      state_n = state;
      cnt_n   = bit_done ? '0 : clk_cnt + 1'b1;
      idx_n   = bit_idx;
      pop     = 1'b0;
      tx_n    = 1'b1;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (hold_brk) begin
               state_n = BRK;
            end else if (!empty) begin
               pop     = 1'b1;
               state_n = START;
            end
         end
         START: begin
            tx_n = 1'b0;
            if (bit_done) begin
               idx_n   = '0;
               state_n = DATA;
            end
         end
         DATA: begin
            tx_n = shift[bit_idx];
            if (bit_done) begin
               if (bit_idx == DATA_LAST) begin
                  idx_n   = '0;
                  state_n = (PARITY != 0) ? PAR : STOP;
               end else begin
                  idx_n = bit_idx + 1'b1;
               end
            end
         end
         PAR: begin
            tx_n = (^shift) ^ ODD;
            if (bit_done) state_n = STOP;
         end
         STOP: begin
            if (bit_done) begin
               if (bit_idx == STOP_LAST) begin
                  idx_n   = '0;
                  state_n = IDLE;
               end else begin
                  idx_n = bit_idx + 1'b1;
               end
            end
         end
         BRK: begin
            tx_n  = 1'b0;
            cnt_n = '0;
            if (!hold_brk) state_n = MARK;
         end
         MARK: begin
            if (bit_done) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Bench: four frame formats at 10 clk/bit (8N1 depth 4, 8E2, 8O2, 5N1); a line monitor checks queued frames.
module tb_uart_tx_fifo;
   localparam int CPB = 10;

   typedef struct {
      logic [15:0] bits;   // line bits in time order, start bit at index 0
      int          len;
      bit          gap;    // next frame must follow after exactly one idle-high clk
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en [4];
   logic [7:0] wr_dat;
   logic       full_w [4], empty_w [4], ovf_w [4], busy_w [4], tx_w [4];
   logic [2:0] lvl_w [4];
   logic [1:0] sel;
   logic       tx_sel;
   bit         mon_en;
   int         checks = 0, errors = 0, frames_done = 0, exp_total = 0;
   frame_t     exp_q [$];
`ifdef UART_TX_BREAK_EN
   logic       brk;
`endif

   always #5 clk = ~clk;
   always_comb tx_sel = tx_w[sel];

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wr_dat),
`ifdef UART_TX_BREAK_EN
      .brk(brk),
`endif
      .full(full_w[0]), .empty(empty_w[0]), .level(lvl_w[0]), .overflow(ovf_w[0]),
      .tx_busy(busy_w[0]), .tx(tx_w[0]));

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) u_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wr_dat),
`ifdef UART_TX_BREAK_EN
      .brk(brk),
`endif
      .full(full_w[1]), .empty(empty_w[1]), .level(lvl_w[1]), .overflow(ovf_w[1]),
      .tx_busy(busy_w[1]), .tx(tx_w[1]));

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) u_c (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wr_dat),
`ifdef UART_TX_BREAK_EN
      .brk(brk),
`endif
      .full(full_w[2]), .empty(empty_w[2]), .level(lvl_w[2]), .overflow(ovf_w[2]),
      .tx_busy(busy_w[2]), .tx(tx_w[2]));

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_d (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en[3]), .wr_data(wr_dat[4:0]),
`ifdef UART_TX_BREAK_EN
      .brk(brk),
`endif
      .full(full_w[3]), .empty(empty_w[3]), .level(lvl_w[3]), .overflow(ovf_w[3]),
      .tx_busy(busy_w[3]), .tx(tx_w[3]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic expect_frame(input logic [15:0] bits, input int len, input bit gap);
      frame_t f;
      f.bits = bits; f.len = len; f.gap = gap;
      exp_q.push_back(f);
      exp_total++;
   endtask

   task automatic push(input int idx, input logic [7:0] d);
      wr_en[idx] = 1'b1;
      wr_dat     = d;
      @(negedge clk);
      wr_en[idx] = 1'b0;
   endtask

   task automatic wait_frames();
      int t = 0;
      while (frames_done < exp_total && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("frames_seen", frames_done, exp_total);
      if (frames_done != exp_total) begin
         exp_q.delete();
         frames_done = exp_total;
      end
   endtask

   // Line monitor: on each start edge pop the expected frame and check every clk of every bit
   initial begin : monitor
      logic        prev, chained, bad;
      logic [15:0] got;
      frame_t      e;
      prev    = 1'b1;
      chained = 1'b0;
      forever begin
         if (!chained) @(negedge clk);
         if (mon_en && !tx_sel && (prev || chained)) begin
            chained = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame sel=%0d got=start_bit exp=idle", sel);
            end else begin
               e   = exp_q.pop_front();
               got = '0;
               bad = 1'b0;
               for (int k = 0; k < e.len; k++) begin
                  for (int c = 0; c < CPB; c++) begin
                     if (k != 0 || c != 0) @(negedge clk);
                     if (tx_sel !== e.bits[k]) bad = 1'b1;
                     if (c == CPB / 2) got[k] = tx_sel;
                  end
               end
               if (e.gap) begin
                  @(negedge clk);
                  if (tx_sel !== 1'b1) bad = 1'b1;
                  @(negedge clk);
                  if (tx_sel !== 1'b0) bad = 1'b1;
                  chained = 1'b1;
               end
               checks++;
               if (bad) begin
                  errors++;
                  $display("FAIL frame sel=%0d got=%h exp=%h (bit timing or gap also checked)",
                           sel, got, e.bits);
               end
               frames_done++;
            end
         end else begin
            chained = 1'b0;
         end
         prev = tx_sel;
      end
   end

   initial begin : stim
      int n;
      logic [2:0] lvl_exp [6];
      bit all_low;
      lvl_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      rst_n  = 1'b0;
      wr_dat = '0;
      sel    = 2'd0;
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) wr_en[i] = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_tx", tx_w[0], 1);
      check("rst_busy", busy_w[0], 0);
      check("rst_empty", empty_w[0], 1);
      check("rst_full", full_w[0], 0);
      check("rst_level", lvl_w[0], 0);
      check("rst_ovf", ovf_w[0], 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 8N1 0xA5: start, 1,0,1,0,0,1,0,1, stop
      expect_frame(16'h034A, 10, 1'b0);
      push(0, 8'hA5);
      check("t1_level_e0", lvl_w[0], 1);
      check("t1_busy_e0", busy_w[0], 1);
      n = 1;
      @(negedge clk);
      check("t1_tx_e1", tx_w[0], 1);
      check("t1_level_e1", lvl_w[0], 0);
      n++;
      @(negedge clk);
      check("t1_tx_e2", tx_w[0], 0);
      n++;
      @(negedge clk);
      while (busy_w[0] && n < 1000) begin
         n++;
         @(negedge clk);
      end
      // busy from the write edge through the 100-clk frame that starts one edge later
      check("t1_busy_cycles", n, 101);
      wait_frames();

      // FIFO fill: 0x01 pops at once, 0x02..0x05 fill depth 4, sixth write overflows
      expect_frame(16'h0202, 10, 1'b1);
      expect_frame(16'h0204, 10, 1'b1);
      expect_frame(16'h0206, 10, 1'b1);
      expect_frame(16'h0208, 10, 1'b1);
      expect_frame(16'h020A, 10, 1'b0);
      for (int i = 0; i < 6; i++) begin
         wr_en[0] = 1'b1;
         wr_dat   = 8'(i + 1);
         @(negedge clk);
         check("t3_level", lvl_w[0], lvl_exp[i]);
         check("t3_full", full_w[0], (i >= 4) ? 1 : 0);
         check("t3_ovf", ovf_w[0], (i == 5) ? 1 : 0);
      end
      wr_en[0] = 1'b0;
      @(negedge clk);
      check("t3_ovf_clear", ovf_w[0], 0);
      check("t3_level_after_drop", lvl_w[0], 4);
      wait_frames();
      check("t3_empty", empty_w[0], 1);
      check("t3_busy", busy_w[0], 0);

      // 8E2: 0xA5 has four ones -> parity 0; 0x07 has three -> parity 1
      sel = 2'd1;
      expect_frame(16'h0D4A, 12, 1'b1);
      expect_frame(16'h0E0E, 12, 1'b0);
      push(1, 8'hA5);
      push(1, 8'h07);
      wait_frames();
      // 8O2: 0xA5 -> parity 1
      sel = 2'd2;
      expect_frame(16'h0F4A, 12, 1'b0);
      push(2, 8'hA5);
      wait_frames();
      // 5N1: 0xFF -> five ones, 70-clk frame
      sel = 2'd3;
      expect_frame(16'h007E, 7, 1'b0);
      push(3, 8'hFF);
      wait_frames();
      check("t4_busy", busy_w[3], 0);

      // Reset mid-frame with three words queued
      sel    = 2'd0;
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_en[0] = 1'b1;
         wr_dat   = 8'(8'h11 + i);
         @(negedge clk);
      end
      wr_en[0] = 1'b0;
      repeat (30) @(negedge clk);
      check("t5_level_before", lvl_w[0], 3);
      #2 rst_n = 1'b0;
      #1;
      check("t5_tx", tx_w[0], 1);
      check("t5_level", lvl_w[0], 0);
      check("t5_empty", empty_w[0], 1);
      check("t5_busy", busy_w[0], 0);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (300) @(negedge clk);
      check("t5_quiet_busy", busy_w[0], 0);
      check("t5_quiet_tx", tx_w[0], 1);

`ifdef UART_TX_BREAK_EN
      // Break held 50 clks with 0x55 queued, then at least one bit of mark before the frame
      mon_en = 1'b0;
      brk    = 1'b1;
      repeat (2) @(negedge clk);
      push(0, 8'h55);
      all_low = 1'b1;
      for (int i = 0; i < 47; i++) begin
         if (tx_w[0] !== 1'b0) all_low = 1'b0;
         @(negedge clk);
      end
      check("t6_line_low", all_low, 1);
      check("t6_no_pop", lvl_w[0], 1);
      check("t6_busy", busy_w[0], 1);
      expect_frame(16'h02AA, 10, 1'b0);
      brk    = 1'b0;
      mon_en = 1'b1;
      n = 0;
      @(negedge clk);
      while (tx_w[0] !== 1'b1 && n < 20) @(negedge clk);
      while (tx_w[0] === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("t6_mark_ge_bit", (n >= CPB) ? 1 : 0, 1);
      wait_frames();
`else
      all_low = 1'b0;
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
